sprite_mem_writer: RTL and testbench

Streaming writer that fills a palette-indexed sprite memory from 24-bit RGB pixels. It is the write-side counterpart of the sprite ROM/palette readers: each incoming colour is encoded back to its palette index, and the index is written to sequential addresses 0..DEPTH-1. It sits between a pixel source (loader FSM, UART bridge or test stimulus) and the write port of a sprite RAM whose read side drives the colour-mapping logic.

---
 rtl/sprite_pkg.sv | 41 ++++
 rtl/palette_match.sv | 44 ++++
 rtl/sprite_mem_writer.sv | 143 ++++++++++++++
 tb/tb_sprite_mem_writer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite memory writer.
// Palette contents, FSM state encoding and the colour distance helper.
package sprite_pkg;

    localparam int SPRITE_DEPTH_DEFAULT = 441;
    localparam int PAL_N = 4;

    localparam logic [23:0] PAL_0 = 24'h800080;
    localparam logic [23:0] PAL_1 = 24'hFFFFFF;
    localparam logic [23:0] PAL_2 = 24'hF83800;
    localparam logic [23:0] PAL_3 = 24'hFFA044;

    typedef logic [PAL_N-1:0][23:0] palette_t;

    localparam palette_t PALETTE = {PAL_3, PAL_2, PAL_1, PAL_0};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Sum of absolute per-channel differences, max 3*255 fits in 10 bits.
    function automatic logic [9:0] l1_dist(
        input logic [23:0] a,
        input logic [23:0] b
    );
        logic [9:0] s;
        logic [7:0] x;
        logic [7:0] y;
        s = '0;
        for (int c = 0; c < 3; c++) begin
            x = a[c*8 +: 8];
            y = b[c*8 +: 8];
            s = s + 10'((x > y) ? (x - y) : (y - x));
        end
        return s;
    endfunction

endpackage

// File: rtl/palette_match.sv
// RGB to palette index encoder. Exact match by default;
// SPRITE_WR_NEAREST_EN selects the nearest entry by L1 distance.
module palette_match
    import sprite_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic [23:0]      in_color,
    output logic [IDX_W-1:0] index,
    output logic             exact
);

`ifdef SPRITE_WR_NEAREST_EN
    logic [9:0] w_best;
    logic [9:0] w_dist;

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        w_best = l1_dist(in_color, PALETTE[0]);
        w_dist = '0;
        index  = '0;
        for (int i = 1; i < PAL_N; i++) begin
            w_dist = l1_dist(in_color, PALETTE[i]);
            if (w_dist < w_best) begin
                w_best = w_dist;
                index  = IDX_W'(i);
            end
        end
        exact = (w_best == '0);
    end
`else
    always_comb begin
        index = '0;
        exact = 1'b0;
        for (int i = 0; i < PAL_N; i++) begin
            if (in_color == PALETTE[i]) begin
                index = IDX_W'(i);
                exact = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/sprite_mem_writer.sv
// Streams RGB pixels into a palette-indexed sprite RAM, addresses 0..DEPTH-1.
// SPRITE_WR_NEAREST_EN adds nearest-colour encoding and a second pipe stage.
module sprite_mem_writer
    import sprite_pkg::*;
#(
    parameter int DEPTH  = SPRITE_DEPTH_DEFAULT,
    parameter int ADDR_W = 9,
    parameter int IDX_W  = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [23:0]       in_color,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_address,
    output logic [IDX_W-1:0]  wr_data,
    output logic              busy,
    output logic              done,
    output logic              err_color
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_C  = (ADDR_W + 1)'(DEPTH - 1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W:0]   r_count;
    logic              w_accept;
    logic              w_last;
    logic              w_pending;
    logic              w_clr;
    logic [IDX_W-1:0]  w_idx;
    logic              w_exact;
    logic              w_st_valid;
    logic [ADDR_W-1:0] w_st_addr;
    logic [IDX_W-1:0]  w_st_idx;
    logic              w_st_exact;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_address;
    logic [IDX_W-1:0]  r_wr_data;
    logic              r_err;

    palette_match #(
        .IDX_W(IDX_W)
    ) u_match (
        .in_color(in_color),
        .index   (w_idx),
        .exact   (w_exact)
    );

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_count == LAST_C);
    assign w_clr    = (r_state == IDLE) && start;

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_accept && w_last) w_next = DRAIN;
            DRAIN:   if (!w_pending) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state == RUN) && (r_count < DEPTH_C);
        busy     = (r_state == RUN) || (r_state == DRAIN);
        done     = (r_state == DONE);
    end

    always_ff @(posedge Clk) begin
        if (Reset)         r_count <= '0;
        else if (w_clr)    r_count <= '0;
        else if (w_accept) r_count <= r_count + 1'b1;
    end

`ifdef SPRITE_WR_NEAREST_EN
    logic              r_s1_valid;
    logic [ADDR_W-1:0] r_s1_addr;
    logic [IDX_W-1:0]  r_s1_idx;
    logic              r_s1_exact;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_s1_valid <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_idx   <= '0;
            r_s1_exact <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_addr  <= r_count[ADDR_W-1:0];
                r_s1_idx   <= w_idx;
                r_s1_exact <= w_exact;
            end
        end
    end

    assign w_st_valid = r_s1_valid;
    assign w_st_addr  = r_s1_addr;
    assign w_st_idx   = r_s1_idx;
    assign w_st_exact = r_s1_exact;
    assign w_pending  = r_s1_valid;
`else
    assign w_st_valid = w_accept;
    assign w_st_addr  = r_count[ADDR_W-1:0];
    assign w_st_idx   = w_idx;
    assign w_st_exact = w_exact;
    assign w_pending  = 1'b0;
`endif

    // Output stage; address and data hold while no write is issued.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wr_en      <= 1'b0;
            r_wr_address <= '0;
            r_wr_data    <= '0;
            r_err        <= 1'b0;
        end else begin
            r_wr_en <= w_st_valid;
            if (w_st_valid) begin
                r_wr_address <= w_st_addr;
                r_wr_data    <= w_st_idx;
            end
            if (w_clr)                          r_err <= 1'b0;
            else if (w_st_valid && !w_st_exact) r_err <= 1'b1;
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_address = r_wr_address;
    assign wr_data    = r_wr_data;
    assign err_color  = r_err;

endmodule

// File: tb/tb_sprite_mem_writer.sv
// Directed bench for sprite_mem_writer: fills, bubbles, bad colour,
// overrun, mid-fill reset and start during RUN.
module tb_sprite_mem_writer;

    localparam int DEPTH = 441;
`ifdef SPRITE_WR_NEAREST_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        Clk;
    logic        Reset;
    logic        start;
    logic        in_valid;
    logic [23:0] in_color;
    logic        in_ready;
    logic        wr_en;
    logic [8:0]  wr_address;
    logic [3:0]  wr_data;
    logic        busy;
    logic        done;
    logic        err_color;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    int wa_q[$];
    int wd_q[$];
    int wc_q[$];
    bit we_q[$];
    int dn_q[$];

    sprite_mem_writer dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_color  (in_color),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_address(wr_address),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .err_color (err_color)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (wr_en) begin
            wa_q.push_back(int'(wr_address));
            wd_q.push_back(int'(wr_data));
            wc_q.push_back(cyc);
            we_q.push_back(err_color);
        end
        if (done) dn_q.push_back(cyc);
    end

    function automatic logic [23:0] pat(input int p);
        case (p % 4)
            0:       return 24'h800080;
            1:       return 24'hFFFFFF;
            2:       return 24'hF83800;
            default: return 24'hFFA044;
        endcase
    endfunction

    task automatic drive_fill(
        input  int bub,
        input  int bad_pos,
        input  int restart_pix,
        input  int stop_at,
        input  bit overrun,
        output int s_cyc,
        output int rdy_hi,
        output bit busy1
    );
        int p;
        int k;
        int g;
        bit acc;
        bit pulsed;
        @(posedge Clk); #1;
        start = 1'b1;
        in_valid = 1'b0;
        s_cyc = cyc;
        @(posedge Clk); #1;
        start = 1'b0;
        busy1 = busy;
        p = 0;
        k = 0;
        g = 0;
        pulsed = 1'b0;
        while (p < DEPTH && g < 3000) begin
            in_valid = !(bub != 0 && (k % bub) == bub - 1);
            in_color = (p == bad_pos) ? 24'h123456 : pat(p);
            start = (p == restart_pix) && !pulsed;
            if (start) pulsed = 1'b1;
            @(negedge Clk);
            acc = in_valid && in_ready;
            @(posedge Clk); #1;
            start = 1'b0;
            if (acc) p++;
            k++;
            g++;
            if (stop_at > 0 && p == stop_at) break;
        end
        rdy_hi = 0;
        if (overrun) begin
            for (int i = 0; i < 10; i++) begin
                in_valid = 1'b1;
                in_color = 24'hFFFFFF;
                if (in_ready) rdy_hi++;
                @(posedge Clk); #1;
            end
        end
        if (stop_at == 0) in_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (dn_q.size() > d0) begin
                ok = 1'b1;
                break;
            end
            @(posedge Clk); #1;
        end
        repeat (3) @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_color = '0;
        repeat (3) @(posedge Clk);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready got=%0d exp=0", in_ready); end
        n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL rst_wr_en got=%0d exp=0", wr_en); end
        n_cmp++; if (wr_address !== 9'd0) begin n_bad++; $display("FAIL rst_wr_address got=%0d exp=0", wr_address); end
        n_cmp++; if (wr_data !== 4'd0) begin n_bad++; $display("FAIL rst_wr_data got=%0d exp=0", wr_data); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%0d exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got=%0d exp=0", done); end
        n_cmp++; if (err_color !== 1'b0) begin n_bad++; $display("FAIL rst_err got=%0d exp=0", err_color); end
        Reset = 1'b0;
        @(posedge Clk); #1;
    endtask

    task automatic test_full_fill;
        int w0, d0, s, rh, n, bad;
        bit b1, ok;
        w0 = wa_q.size();
        d0 = dn_q.size();
        drive_fill(0, -1, -1, 0, 1'b0, s, rh, b1);
        wait_done(d0, ok);
        n = wa_q.size() - w0;
        bad = 0;
        for (int i = 0; i < n; i++)
            if (wa_q[w0+i] != i || wd_q[w0+i] != i % 4) bad++;
        n_cmp++; if (b1 !== 1'b1) begin n_bad++; $display("FAIL full_busy_c1 got=%0d exp=1", b1); end
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL full_done_seen got=%0d exp=1", ok); end
        n_cmp++; if (n != DEPTH) begin n_bad++; $display("FAIL full_write_count got=%0d exp=%0d", n, DEPTH); end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL full_addr_data got=%0d bad exp=0", bad); end
        n_cmp++; if ((n > 0 ? wc_q[w0] - s : -1) != 1 + LAT) begin n_bad++; $display("FAIL full_first_write got=%0d exp=%0d", n > 0 ? wc_q[w0] - s : -1, 1 + LAT); end
        n_cmp++; if ((n > 0 ? wc_q[w0+n-1] - s : -1) != DEPTH + LAT) begin n_bad++; $display("FAIL full_last_write got=%0d exp=%0d", n > 0 ? wc_q[w0+n-1] - s : -1, DEPTH + LAT); end
        n_cmp++; if ((ok ? dn_q[d0] - s : -1) != DEPTH + 1 + LAT) begin n_bad++; $display("FAIL full_done_cycle got=%0d exp=%0d", ok ? dn_q[d0] - s : -1, DEPTH + 1 + LAT); end
        n_cmp++; if (dn_q.size() - d0 != 1) begin n_bad++; $display("FAIL full_done_pulses got=%0d exp=1", dn_q.size() - d0); end
        n_cmp++; if (err_color !== 1'b0) begin n_bad++; $display("FAIL full_err got=%0d exp=0", err_color); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL full_busy_end got=%0d exp=0", busy); end
    endtask

    task automatic test_bubbles;
        int w0, d0, s, rh, n, bad;
        bit b1, ok;
        w0 = wa_q.size();
        d0 = dn_q.size();
        drive_fill(3, -1, -1, 0, 1'b0, s, rh, b1);
        wait_done(d0, ok);
        n = wa_q.size() - w0;
        bad = 0;
        for (int i = 0; i < n; i++)
            if (wa_q[w0+i] != i || wd_q[w0+i] != i % 4) bad++;
        n_cmp++; if (n != DEPTH) begin n_bad++; $display("FAIL bub_write_count got=%0d exp=%0d", n, DEPTH); end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL bub_addr_data got=%0d bad exp=0", bad); end
        n_cmp++; if ((ok && n > 0 ? dn_q[d0] - wc_q[w0+n-1] : -1) != 1) begin n_bad++; $display("FAIL bub_done_gap got=%0d exp=1", ok && n > 0 ? dn_q[d0] - wc_q[w0+n-1] : -1); end
    endtask

    task automatic test_bad_color;
        int w0, d0, s, rh, n;
        bit b1, ok;
        w0 = wa_q.size();
        d0 = dn_q.size();
        drive_fill(0, 5, -1, 0, 1'b0, s, rh, b1);
        wait_done(d0, ok);
        n = wa_q.size() - w0;
        n_cmp++; if ((n > 5 ? wa_q[w0+5] : -1) != 5) begin n_bad++; $display("FAIL bad_addr got=%0d exp=5", n > 5 ? wa_q[w0+5] : -1); end
        n_cmp++; if ((n > 5 ? wd_q[w0+5] : -1) != 0) begin n_bad++; $display("FAIL bad_data got=%0d exp=0", n > 5 ? wd_q[w0+5] : -1); end
        n_cmp++; if ((n > 5 ? we_q[w0+4] : 1'b1) !== 1'b0) begin n_bad++; $display("FAIL bad_err_before got=%0d exp=0", n > 5 ? we_q[w0+4] : 1'b1); end
        n_cmp++; if ((n > 5 ? we_q[w0+5] : 1'b0) !== 1'b1) begin n_bad++; $display("FAIL bad_err_rise got=%0d exp=1", n > 5 ? we_q[w0+5] : 1'b0); end
        n_cmp++; if ((n > 6 ? wd_q[w0+6] : -1) != 2) begin n_bad++; $display("FAIL bad_next_data got=%0d exp=2", n > 6 ? wd_q[w0+6] : -1); end
        repeat (3) @(posedge Clk);
        #1;
        n_cmp++; if (err_color !== 1'b1) begin n_bad++; $display("FAIL bad_err_sticky got=%0d exp=1", err_color); end
        start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        n_cmp++; if (err_color !== 1'b0) begin n_bad++; $display("FAIL bad_err_clear got=%0d exp=0", err_color); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL bad_restart_busy got=%0d exp=1", busy); end
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
    endtask

    task automatic test_overrun;
        int w0, d0, s, rh, n;
        bit b1, ok;
        w0 = wa_q.size();
        d0 = dn_q.size();
        drive_fill(0, -1, -1, 0, 1'b1, s, rh, b1);
        wait_done(d0, ok);
        n = wa_q.size() - w0;
        n_cmp++; if (rh != 0) begin n_bad++; $display("FAIL ovr_in_ready got=%0d exp=0", rh); end
        n_cmp++; if (n != DEPTH) begin n_bad++; $display("FAIL ovr_write_count got=%0d exp=%0d", n, DEPTH); end
        n_cmp++; if ((n > 0 ? wa_q[w0+n-1] : -1) != DEPTH - 1) begin n_bad++; $display("FAIL ovr_last_addr got=%0d exp=%0d", n > 0 ? wa_q[w0+n-1] : -1, DEPTH - 1); end
    endtask

    task automatic test_reset_mid;
        int w0, d0, s, rh, n, nr, bad;
        bit b1, ok;
        w0 = wa_q.size();
        drive_fill(0, -1, -1, 100, 1'b0, s, rh, b1);
        Reset = 1'b1;
        in_valid = 1'b0;
        @(posedge Clk); #1;
        nr = wa_q.size() - w0;
        n_cmp++; if ({in_ready, wr_en, wr_address, wr_data, busy, done, err_color} !== 18'd0) begin
            n_bad++;
            $display("FAIL mid_rst_outputs got=%0h exp=0", {in_ready, wr_en, wr_address, wr_data, busy, done, err_color});
        end
        n_cmp++; if (nr != 101 - LAT) begin n_bad++; $display("FAIL mid_rst_writes got=%0d exp=%0d", nr, 101 - LAT); end
        Reset = 1'b0;
        repeat (5) @(posedge Clk);
        #1;
        n_cmp++; if (wa_q.size() - w0 != nr) begin n_bad++; $display("FAIL mid_rst_pending got=%0d exp=%0d", wa_q.size() - w0, nr); end
        w0 = wa_q.size();
        d0 = dn_q.size();
        drive_fill(0, -1, -1, 0, 1'b0, s, rh, b1);
        wait_done(d0, ok);
        n = wa_q.size() - w0;
        bad = 0;
        for (int i = 0; i < n; i++)
            if (wa_q[w0+i] != i) bad++;
        n_cmp++; if ((n > 0 ? wa_q[w0] : -1) != 0) begin n_bad++; $display("FAIL mid_restart_addr0 got=%0d exp=0", n > 0 ? wa_q[w0] : -1); end
        n_cmp++; if (n != DEPTH || bad != 0) begin n_bad++; $display("FAIL mid_restart_fill got=%0d writes %0d bad exp=%0d writes 0 bad", n, bad, DEPTH); end
    endtask

    task automatic test_start_during_run;
        int w0, d0, s, rh, n, bad;
        bit b1, ok;
        w0 = wa_q.size();
        d0 = dn_q.size();
        drive_fill(0, -1, 50, 0, 1'b0, s, rh, b1);
        wait_done(d0, ok);
        n = wa_q.size() - w0;
        bad = 0;
        for (int i = 0; i < n; i++)
            if (wa_q[w0+i] != i) bad++;
        n_cmp++; if ((n > 51 ? wa_q[w0+51] : -1) != 51) begin n_bad++; $display("FAIL sdr_addr51 got=%0d exp=51", n > 51 ? wa_q[w0+51] : -1); end
        n_cmp++; if (n != DEPTH || bad != 0) begin n_bad++; $display("FAIL sdr_fill got=%0d writes %0d bad exp=%0d writes 0 bad", n, bad, DEPTH); end
        n_cmp++; if ((ok ? dn_q[d0] - s : -1) != DEPTH + 1 + LAT) begin n_bad++; $display("FAIL sdr_done_cycle got=%0d exp=%0d", ok ? dn_q[d0] - s : -1, DEPTH + 1 + LAT); end
    endtask

    initial begin
        Reset = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_color = '0;
        test_reset();
        test_full_fill();
        test_bubbles();
        test_bad_color();
        test_overrun();
        test_reset_mid();
        test_start_during_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
